serial_logic_unit: RTL and testbench

- Bit-serial 16-bit logic unit: one shared 1-bit gate slice evaluated once per cycle, LSB first, across the whole word.
- Sequences the gate over the operand bits, collects the result bits and signals completion with a start/busy/done handshake.
- Sits between the chip-level test and CPU scaffolding and the primitive gate layer; it is the resource controller that time-shares a single gate instance.

---
 rtl/serial_logic_unit_if.sv | 42 ++++
 rtl/serial_logic_unit.sv | 147 ++++++++++++++
 tb/tb_serial_logic_unit.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_logic_unit_if.sv
// ---------------------------------------------------------------------------
// serial_logic_unit_if
//
// Purpose: bundles the request/result signals of serial_logic_unit.
//
// Handshake: the requester raises start with op/a/b valid. start is only
// looked at while busy is low. The edge that sees start=1 with busy low
// accepts the request. No other start is taken until done has pulsed and
// busy has dropped. done is a one-cycle pulse and out is valid during it.
// out then holds until the next completion.
//
// Signals:
//   start  requester -> unit   request strobe
//   op     requester -> unit   2-bit opcode (00 OR, 01 AND, 10 XOR, 11 NOT a)
//   a, b   requester -> unit   WIDTH-bit operands
//   busy   unit -> requester   high while an operation is in flight
//   done   unit -> requester   one-cycle completion pulse
//   out    unit -> requester   WIDTH-bit registered result
//   zr     unit -> requester   out == 0 flag (only with SERIAL_ZR_EN)
//
// Build option: define SERIAL_ZR_EN to add the zr flag.
// ---------------------------------------------------------------------------
interface serial_logic_unit_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
`ifdef SERIAL_ZR_EN
    logic             zr;

    modport master (output start, op, a, b, input busy, done, out, zr);
    modport slave  (input start, op, a, b, output busy, done, out, zr);
`else
    modport master (output start, op, a, b, input busy, done, out);
    modport slave  (input start, op, a, b, output busy, done, out);
`endif
endinterface

// File: rtl/serial_logic_unit.sv
// ---------------------------------------------------------------------------
// serial_logic_unit
//
// Purpose: bit-serial WIDTH-bit logic unit. A single 1-bit gate slice is
// reused once per cycle, LSB first. The result bits collect in an
// accumulator. out is loaded only when the last bit is computed, so it
// never shows a partial result.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bus          serial_logic_unit_if.slave (start/op/a/b in, busy/done/out[/zr] out)
//   o_dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Build option: SERIAL_ZR_EN adds the zr flag. zr is 1 when out == 0.
//
// Timing: edge E0 accepts start. Edges E1..E_WIDTH evaluate bits
// 0..WIDTH-1. done and the new out are visible in the cycle after E_WIDTH.
// ---------------------------------------------------------------------------
module serial_logic_unit #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_logic_unit_if.slave   bus,
    output logic [1:0]           o_dbg_state
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_out;
    logic             r_busy;
    logic             r_done;
`ifdef SERIAL_ZR_EN
    logic             r_nz;
    logic             r_zr;
`endif

    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_gate_bit;
    logic [WIDTH-1:0] w_acc_next;

    // The shared gate slice works on the operand bits selected by the counter.
    assign w_a_bit = r_a[r_cnt];
    assign w_b_bit = r_b[r_cnt];

    always_comb begin
        w_gate_bit = 1'b0;
        case (r_op)
            2'b00:   w_gate_bit = w_a_bit | w_b_bit;
            2'b01:   w_gate_bit = w_a_bit & w_b_bit;
            2'b10:   w_gate_bit = w_a_bit ^ w_b_bit;
            default: w_gate_bit = ~w_a_bit;   // NOT a; b is ignored
        endcase
    end

    // The accumulator value including this cycle's bit. The last bit feeds
    // out directly, so completion needs no extra cycle.
    assign w_acc_next = r_acc | (WIDTH'(w_gate_bit) << r_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= 2'b00;
            r_acc   <= '0;
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SERIAL_ZR_EN
            r_nz    <= 1'b0;
            r_zr    <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_op    <= bus.op;
                        r_cnt   <= '0;
                        r_acc   <= '0;
`ifdef SERIAL_ZR_EN
                        r_nz    <= 1'b0;
`endif
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_next;
`ifdef SERIAL_ZR_EN
                    r_nz  <= r_nz | w_gate_bit;
`endif
                    if (r_cnt == LAST_BIT) begin
                        r_out   <= w_acc_next;
`ifdef SERIAL_ZR_EN
                        r_zr    <= ~(r_nz | w_gate_bit);
`endif
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    // start is ignored on this edge. The next accept can
                    // happen one edge later, from IDLE.
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.out     = r_out;
`ifdef SERIAL_ZR_EN
    assign bus.zr      = r_zr;
`endif
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_logic_unit.sv
// ---------------------------------------------------------------------------
// tb_serial_logic_unit
//
// Self-checking bench for serial_logic_unit (WIDTH=16).
// - A behavioural model computes each result as a whole-word operation.
// - The model tracks timing as "done WIDTH edges after accept, idle one
//   edge later".
// - A compare process checks busy/done/out[/zr] against the model on every
//   negative clock edge.
// - Results are also queued at accept and popped on each done pulse.
// - Directed cases pin the model with literal expected values.
// - A random phase drives $urandom stimulus.
// Build option: SERIAL_ZR_EN also checks zr.
// ---------------------------------------------------------------------------
module tb_serial_logic_unit;

    localparam int W = 16;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         cyc;
    int         n_checks;
    int         n_fail;

    serial_logic_unit_if #(.WIDTH(W)) bus_if ();

    serial_logic_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_if),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            2'b00:   return a | b;
            2'b01:   return a & b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    logic           m_busy;
    logic           m_done;
    logic [W-1:0]   m_out;
    logic [W-1:0]   m_pend;
    int             m_left;
    logic [W-1:0]   exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_out  = '0;
            m_left = 0;
            exp_q.delete();
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_out  = m_pend;
            end
        end else if (bus_if.start) begin
            m_busy = 1'b1;
            m_left = W;
            m_pend = ref_op(bus_if.op, bus_if.a, bus_if.b);
            exp_q.push_back(m_pend);
        end
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        logic [W-1:0] q_exp;
        check("busy", {31'd0, bus_if.busy}, {31'd0, m_busy});
        check("done", {31'd0, bus_if.done}, {31'd0, m_done});
        check("out",  32'(bus_if.out), 32'(m_out));
`ifdef SERIAL_ZR_EN
        check("zr", {31'd0, bus_if.zr}, {31'd0, (m_out == '0)});
`endif
        if (bus_if.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("done_without_request", 32'd1, 32'd0);
            end else begin
                q_exp = exp_q.pop_front();
                check("queued_result", 32'(bus_if.out), 32'(q_exp));
            end
        end
    end

    // ---------------- driver tasks ----------------
    int c0;

    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #1;
        bus_if.start = 1'b1;
        bus_if.op    = op;
        bus_if.a     = a;
        bus_if.b     = b;
        @(posedge clk);
        #1;
        c0 = cyc;                     // accept edge
        bus_if.start = 1'b0;
        bus_if.a     = W'($urandom);  // latched copies must be used
        bus_if.b     = W'($urandom);
    endtask

    // Waits at negedges for done. t is the cycle count at that point, or -1 on timeout.
    task automatic wait_done(input string name, output int t);
        t = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus_if.done === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_lit);
        int t;
        start_op(op, a, b);
        wait_done(name, t);
        check(name, 32'(bus_if.out), 32'(exp_lit));
        if (t >= 0) check({name, "_latency"}, 32'(t - c0 + 1), 32'd17);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t1;
        int t2;
        int ndone;
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus_if.start = 1'b0;
        bus_if.op    = 2'b00;
        bus_if.a     = '0;
        bus_if.b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out",   32'(bus_if.out), 32'h0);
        check("reset_busy",  {31'd0, bus_if.busy}, 32'd0);
        check("reset_done",  {31'd0, bus_if.done}, 32'd0);
        check("reset_state", {30'd0, dbg_state}, 32'd0);
`ifdef SERIAL_ZR_EN
        check("reset_zr",    {31'd0, bus_if.zr}, 32'd1);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed cases with literal results
        start_op(2'b00, 16'h00F0, 16'h0F00);
        check("busy_after_accept", {31'd0, bus_if.busy}, 32'd1);
        wait_done("or_op", t1);
        check("or_out", 32'(bus_if.out), 32'h0FF0);
        if (t1 >= 0) check("or_latency", 32'(t1 - c0 + 1), 32'd17);
        @(posedge clk);
        #1;
        check("busy_low_after_done", {31'd0, bus_if.busy}, 32'd0);

        run_op("and_out", 2'b01, 16'hFFFF, 16'h1234, 16'h1234);
        run_op("xor_out", 2'b10, 16'hAAAA, 16'hFFFF, 16'h5555);
        run_op("not_out", 2'b11, 16'h00FF, 16'h1357, 16'hFF00);

        // Back-to-back: start held high, a changed mid-RUN
        @(posedge clk);
        #1;
        bus_if.start = 1'b1;
        bus_if.op    = 2'b00;
        bus_if.a     = 16'h0001;
        bus_if.b     = 16'h0000;
        repeat (6) @(posedge clk);
        #1;
        bus_if.a = 16'hFFFF;
        wait_done("b2b_first", t1);
        check("b2b_first_out", 32'(bus_if.out), 32'h0001);
        wait_done("b2b_second", t2);
        check("b2b_second_out", 32'(bus_if.out), 32'hFFFF);
        if (t1 >= 0 && t2 >= 0) check("b2b_period", 32'(t2 - t1), 32'd18);
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        repeat (20) @(posedge clk);

        // Reset mid-operation
        run_op("pre_reset_out", 2'b00, 16'h00F0, 16'h0F00, 16'h0FF0);
        start_op(2'b10, 16'h1234, 16'h00FF);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out",  32'(bus_if.out), 32'h0);
        check("midrst_busy", {31'd0, bus_if.busy}, 32'd0);
`ifdef SERIAL_ZR_EN
        check("midrst_zr",   {31'd0, bus_if.zr}, 32'd1);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus_if.done === 1'b1) ndone++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);

        run_op("zero_and_out", 2'b01, 16'h0000, 16'hFFFF, 16'h0000);
`ifdef SERIAL_ZR_EN
        check("zero_and_zr", {31'd0, bus_if.zr}, 32'd1);
`endif
        run_op("msb_or_out", 2'b00, 16'h8000, 16'h0000, 16'h8000);
`ifdef SERIAL_ZR_EN
        check("msb_or_zr", {31'd0, bus_if.zr}, 32'd0);
`endif

        // Random phase: frequent start requests, including during busy
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            bus_if.start = ($urandom_range(0, 3) == 0);
            bus_if.op    = 2'($urandom_range(0, 3));
            bus_if.a     = W'($urandom);
            bus_if.b     = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 9) == 0) bus_if.a = '0;
        end
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        repeat (25) @(posedge clk);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
